sca_sparse_mac_gen: RTL
=======================

// Module: sca_sparse_mac_gen
// PURPOSE
//  List-driven sparse conv accumulator for the SFTM conv/deconv path. Generalises the SCA core to
//  N_OC output channels, NNZ list entries per tile, any N_ROWS x N_COLS tile, and multi-tile
//  (input-channel) accumulation. Uses valid/ready on both sides and saturating accumulators.
//  It sits between the tile fetcher and the post-processing and requant stage.
// PARAMETERS
//  DATA_W  16  activation/weight width, signed
//  ACC_W   32  accumulator/output width, signed; must be >= 2*DATA_W
//  N_ROWS  4   tile rows
//  N_COLS  4   tile cols; N_PIX = N_ROWS*N_COLS, PIX_BITS = max(1,$clog2(N_PIX))
//  N_OC    3   output channels; OC_BITS = max(1,$clog2(N_OC))
//  NNZ     18  list entries per tile; IDX_W = 1+OC_BITS+2*PIX_BITS
// PORTS
//  clk       in   1                   clock
//  rst       in   1                   synchronous reset, active-high
//  in_valid  in   1                   tile + list valid
//  in_ready  out  1                   block can accept a tile
//  in_last   in   1                   last tile of the accumulation group
//  y_in      in   N_PIX*DATA_W        activations; pixel p at [p*DATA_W +: DATA_W], p = r*N_COLS+c
//  w_in      in   NNZ*DATA_W          sparse weights; entry k at [k*DATA_W +: DATA_W]
//  idx_in    in   NNZ*IDX_W           entry k = {en, oc, src, dst}, en at the MSB
//  out_valid out  1                   result valid
//  out_ready in   1                   downstream accepts the result
//  u_out     out  N_OC*N_PIX*ACC_W    result; (oc,p) at [(oc*N_PIX+p)*ACC_W +: ACC_W]
//  out_sat   out  1                   sticky: saturation occurred in this group
//  idx_err   out  1                   sticky: an entry was skipped for out-of-range oc/src/dst
//  mac_cnt   out  16                  MACs executed in this group (saturates at 16'hFFFF)
//  busy      out  1                   state != IDLE
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, psum/u_out=0, out_valid=0, out_sat=0, idx_err=0,
//   mac_cnt=0, grp_open=0. in_ready=0 during any cycle with rst=1. A reset mid-RUN or mid-EMIT
//   discards the in-flight group with no output.
//  FSM IDLE -> RUN -> (IDLE | EMIT) -> IDLE:
//   IDLE: in_ready=1 when rst=0. On in_valid&&in_ready, latch y_in, w_in, idx_in and in_last,
//    set k=0, go to RUN. If grp_open==0, also clear psum, sat, err and cnt, then set grp_open=1.
//   RUN: one entry per cycle, entry k. MAC when en && w!=0 && oc<N_OC && src<N_PIX && dst<N_PIX:
//    psum[oc][dst] <= sat(psum[oc][dst] + sext(y[src]*w)); mac_cnt += 1.
//    en && w!=0 with any range check failing -> entry skipped, idx_err=1.
//    en==0 or w==0 -> no-op, not counted.
//    At k==NNZ-1: if latched last, go EMIT (u_out <= psum with the final update applied),
//    else go IDLE with grp_open held at 1.
//   EMIT: out_valid=1. u_out, out_sat, idx_err and mac_cnt stay stable until out_ready.
//    On out_valid&&out_ready: out_valid=0, grp_open=0, go IDLE.
//  Handshake: in_ready is 0 outside IDLE, so there is no input skid. in_valid during RUN or EMIT
//   is ignored and must be held by the source. out_ready may be high before out_valid.
//  Latency: tile accepted at edge t; entries processed at t+1..t+NNZ; out_valid high from t+NNZ+1
//   for a last tile. Throughput is one tile per NNZ+1 cycles, plus EMIT cycles on group end.
//  Arithmetic: product is DATA_W x DATA_W signed -> 2*DATA_W, sign-extended to ACC_W. The add is
//   done at ACC_W+1 bits and clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; a clamp sets out_sat.
//   Pixels never written by a MAC output 0.
//  Two entries with the same (oc,dst) in one tile accumulate sequentially; both are counted.
//  mac_cnt saturates at 16'hFFFF and does not wrap.
//  u_out, out_sat, idx_err and mac_cnt are valid only while out_valid=1; between outputs they
//   hold their last emitted values.
// TESTING
//  T1 single tile: y[p]=p+1; entry0={1,oc0,src5,dst0,w=2}, entry1={1,oc2,src15,dst15,w=-3},
//     rest en=0; in_last=1 -> u[0][0]=12, u[2][15]=-48, all else 0; mac_cnt=2; out_valid at t+19.
//  T2 2-tile group: tile A y=all 1, entry0={1,oc1,src0,dst3,w=4}, last=0; tile B y=all 2, same
//     entry, last=1 -> single output with u[1][3]=12 and no output after tile A.
//  T3 saturation: ACC_W=32, DATA_W=16; y[0]=-32768, w=-32768 in 3 entries to (0,0)
//     -> u[0][0]=2147483647, out_sat=1.
//  T4 bad index: entry oc=3 (N_OC=3), w=5 -> skipped, idx_err=1, mac_cnt excludes it;
//     a w=0 entry is not counted.
//  T5 backpressure: hold out_ready=0 for 10 cycles -> out_valid and u_out stable, in_ready=0
//     throughout; out_ready=1 -> in_ready=1 on the next cycle.
//  T6 reset at RUN k=7 -> next cycle state IDLE, out_valid=0, u_out=0; a new single tile then
//     gives T1 results. Repeat T1 with N_ROWS=N_COLS=6, N_OC=1.

Source files
------------

// File: rtl/sca_sparse_mac_gen.sv
// Sparse conv accumulator: walks a per-tile list of {en, oc, src, dst, w} entries and
// accumulates y[src]*w into psum[oc][dst] with saturation, across a group of input-channel tiles.
// Latency: tile accepted at edge t, entries at t+1..t+NNZ, out_valid from t+NNZ+1 on a last tile.
// Backpressure: in_ready only in IDLE (no skid); EMIT holds all results until out_ready.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid/in_ready/in_last  tile handshake; in_last closes the accumulation group
//   y_in                       N_PIX activations, pixel p = r*N_COLS+c at [p*DATA_W +: DATA_W]
//   w_in, idx_in               NNZ sparse weights and {en, oc, src, dst} descriptors
//   out_valid/out_ready        result handshake
//   u_out                      N_OC*N_PIX accumulators, (oc,p) at [(oc*N_PIX+p)*ACC_W +: ACC_W]
//   out_sat, idx_err, mac_cnt  group status, sticky over the group, held between outputs
//   busy                       FSM not idle
module sca_sparse_mac_gen #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int N_ROWS = 4,
  parameter int N_COLS = 4,
  parameter int N_OC   = 3,
  parameter int NNZ    = 18,
  localparam int N_PIX    = N_ROWS * N_COLS,
  localparam int PIX_BITS = (N_PIX > 1) ? $clog2(N_PIX) : 1,
  localparam int OC_BITS  = (N_OC > 1) ? $clog2(N_OC) : 1,
  localparam int IDX_W    = 1 + OC_BITS + 2 * PIX_BITS,
  localparam int N_ACC    = N_OC * N_PIX
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic [N_PIX*DATA_W-1:0]      y_in,
  input  logic [NNZ*DATA_W-1:0]        w_in,
  input  logic [NNZ*IDX_W-1:0]         idx_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_ACC*ACC_W-1:0]       u_out,
  output logic                         out_sat,
  output logic                         idx_err,
  output logic [15:0]                  mac_cnt,
  output logic                         busy
);

  localparam int K_W    = (NNZ > 1) ? $clog2(NNZ) : 1;
  localparam int ACC_IW = (N_ACC > 1) ? $clog2(N_ACC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_EMIT} state_e;

  state_e                    state_q, state_d;
  logic [K_W-1:0]            k_q, k_d;
  logic signed [DATA_W-1:0]  y_q [N_PIX];
  logic signed [DATA_W-1:0]  y_d [N_PIX];
  logic signed [DATA_W-1:0]  w_q [NNZ];
  logic signed [DATA_W-1:0]  w_d [NNZ];
  logic [IDX_W-1:0]          idx_q [NNZ];
  logic [IDX_W-1:0]          idx_d [NNZ];
  logic                      last_q, last_d;
  logic                      grp_open_q, grp_open_d;
  logic signed [ACC_W-1:0]   psum_q [N_ACC];
  logic signed [ACC_W-1:0]   psum_d [N_ACC];
  logic signed [ACC_W-1:0]   u_q [N_ACC];
  logic signed [ACC_W-1:0]   u_d [N_ACC];
  logic                      sat_q, sat_d;
  logic                      err_q, err_d;
  logic [15:0]               cnt_q, cnt_d;
  logic                      out_valid_q, out_valid_d;
  logic                      out_sat_q, out_sat_d;
  logic                      idx_err_q, idx_err_d;
  logic [15:0]               mac_cnt_q, mac_cnt_d;

  // Current list entry decode and MAC datapath
  logic [IDX_W-1:0]          ent;
  logic signed [DATA_W-1:0]  w_cur;
  logic signed [DATA_W-1:0]  y_sel;
  logic                      e_en;
  logic [OC_BITS-1:0]        e_oc;
  logic [PIX_BITS-1:0]       e_src;
  logic [PIX_BITS-1:0]       e_dst;
  logic                      oc_ok, src_ok, dst_ok;
  logic                      active, do_mac, bad_idx;
  logic [ACC_IW-1:0]         acc_idx;
  logic signed [2*DATA_W-1:0] prod;
  logic [ACC_W:0]            sum;
  logic                      ovf;
  logic [ACC_W-1:0]          mac_val;

  always_comb begin
    ent    = idx_q[k_q];
    w_cur  = w_q[k_q];
    e_en   = ent[IDX_W-1];
    e_oc   = ent[IDX_W-2 -: OC_BITS];
    e_src  = ent[2*PIX_BITS-1 -: PIX_BITS];
    e_dst  = ent[PIX_BITS-1:0];
    oc_ok  = int'(e_oc) < N_OC;
    src_ok = int'(e_src) < N_PIX;
    dst_ok = int'(e_dst) < N_PIX;
    active  = e_en && (w_cur != '0);
    do_mac  = active && oc_ok && src_ok && dst_ok;
    bad_idx = active && !(oc_ok && src_ok && dst_ok);
    // Out-of-range fields are steered to index 0 so the datapath never reads past an array;
    // the result is discarded anyway because do_mac is low.
    y_sel   = y_q[src_ok ? e_src : '0];
    acc_idx = (oc_ok && dst_ok) ? ACC_IW'(int'(e_oc) * N_PIX + int'(e_dst)) : '0;
    prod    = y_sel * w_cur;
    // One guard bit: overflow shows up as the top two bits disagreeing.
    sum = {psum_q[acc_idx][ACC_W-1], psum_q[acc_idx]}
        + {{(ACC_W+1-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    ovf = sum[ACC_W] ^ sum[ACC_W-1];
    if (!ovf)
      mac_val = sum[ACC_W-1:0];
    else if (sum[ACC_W])
      mac_val = {1'b1, {(ACC_W-1){1'b0}}};
    else
      mac_val = {1'b0, {(ACC_W-1){1'b1}}};
  end

  assign in_ready = (state_q == S_IDLE) && !rst;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    y_d         = y_q;
    w_d         = w_q;
    idx_d       = idx_q;
    last_d      = last_q;
    grp_open_d  = grp_open_q;
    psum_d      = psum_q;
    u_d         = u_q;
    sat_d       = sat_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_sat_d   = out_sat_q;
    idx_err_d   = idx_err_q;
    mac_cnt_d   = mac_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          for (int p = 0; p < N_PIX; p++) y_d[p] = y_in[p*DATA_W +: DATA_W];
          for (int k = 0; k < NNZ; k++) begin
            w_d[k]   = w_in[k*DATA_W +: DATA_W];
            idx_d[k] = idx_in[k*IDX_W +: IDX_W];
          end
          last_d  = in_last;
          k_d     = '0;
          state_d = S_RUN;
          // First tile of a group starts from a clean accumulator and clean status.
          if (!grp_open_q) begin
            for (int i = 0; i < N_ACC; i++) psum_d[i] = '0;
            sat_d      = 1'b0;
            err_d      = 1'b0;
            cnt_d      = '0;
            grp_open_d = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (do_mac) begin
          psum_d[acc_idx] = mac_val;
          if (ovf) sat_d = 1'b1;
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end
        if (bad_idx) err_d = 1'b1;
        if (k_q == K_W'(NNZ - 1)) begin
          if (last_q) begin
            // Snapshot includes this final entry's update.
            u_d         = psum_d;
            out_sat_d   = sat_d;
            idx_err_d   = err_d;
            mac_cnt_d   = cnt_d;
            out_valid_d = 1'b1;
            state_d     = S_EMIT;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          k_d = k_q + K_W'(1);
        end
      end

      S_EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          grp_open_d  = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      last_q      <= 1'b0;
      grp_open_q  <= 1'b0;
      sat_q       <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
      idx_err_q   <= 1'b0;
      mac_cnt_q   <= '0;
      for (int p = 0; p < N_PIX; p++) y_q[p] <= '0;
      for (int k = 0; k < NNZ; k++) begin
        w_q[k]   <= '0;
        idx_q[k] <= '0;
      end
      for (int i = 0; i < N_ACC; i++) begin
        psum_q[i] <= '0;
        u_q[i]    <= '0;
      end
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      last_q      <= last_d;
      grp_open_q  <= grp_open_d;
      sat_q       <= sat_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_sat_q   <= out_sat_d;
      idx_err_q   <= idx_err_d;
      mac_cnt_q   <= mac_cnt_d;
      y_q         <= y_d;
      w_q         <= w_d;
      idx_q       <= idx_d;
      psum_q      <= psum_d;
      u_q         <= u_d;
    end
  end

  always_comb begin
    u_out = '0;
    for (int i = 0; i < N_ACC; i++) u_out[i*ACC_W +: ACC_W] = u_q[i];
  end

  assign out_valid = out_valid_q;
  assign out_sat   = out_sat_q;
  assign idx_err   = idx_err_q;
  assign mac_cnt   = mac_cnt_q;
  assign busy      = (state_q != S_IDLE);

endmodule
